// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types used by the pipeline control logic.
//   REGBITS        - width of a register-file index
//   regbits_t      - register index type
//   hazard_state_t - stall/flush controller FSM states
package cpu_types_pkg;

   localparam int REGBITS = 5;

   typedef logic [REGBITS-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is a source of the
// instruction in DE, which forwarding cannot cover.
//   ex_memread - EX instruction is a load
//   ex_rt      - destination of that load
//   de_rs      - DE source register rs
//   de_rt      - DE source register rt
//   de_uses_rt - DE instruction actually reads rt
//   hazard     - one bubble is required
module load_use_detect
   import cpu_types_pkg::*;
(
   input  logic     ex_memread,
   input  regbits_t ex_rt,
   input  regbits_t de_rs,
   input  regbits_t de_rt,
   input  logic     de_uses_rt,
   output logic     hazard
);

   logic rs_match_s;
   logic rt_match_s;

   // Register 0 is hard-wired, so a load into it never creates a dependency.
   always_comb begin
      rs_match_s = (ex_rt == de_rs);
      rt_match_s = de_uses_rt & (ex_rt == de_rt);
      hazard     = ex_memread & (ex_rt != {REGBITS{1'b0}}) & (rs_match_s | rt_match_s);
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall/flush controller for the 5-stage pipeline.
// Drives pause/bubble controls of the FD, DE, EM and MW latches and the PC
// enable; tracks data-memory wait and halt in a small FSM and counts stall and
// flush cycles in saturating counters.
//   CLK, nRST            - clock, async active-low reset
//   ihit, dhit           - instruction / data memory completion
//   mem_dren, mem_dwen   - MEM-stage load / store
//   mem_redirect         - taken branch/jump resolved in MEM
//   mem_halt             - halt instruction in MEM
//   ex_memread, ex_rt    - EX-stage load and its destination
//   de_rs, de_rt, de_uses_rt - DE-stage sources
//   pc_en                - PC loads next value
//   *_pause / *_nop      - latch hold / bubble (nop overrides pause)
//   halt, dwait          - FSM status
//   stall_cnt, flush_cnt - saturating performance counters
module pipeline_hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dren,
   input  logic             mem_dwen,
   input  logic             mem_redirect,
   input  logic             mem_halt,
   input  logic             ex_memread,
   input  regbits_t         ex_rt,
   input  regbits_t         de_rs,
   input  regbits_t         de_rt,
   input  logic             de_uses_rt,
   output logic             pc_en,
   output logic             fd_pause,
   output logic             de_pause,
   output logic             em_pause,
   output logic             mw_pause,
   output logic             fd_nop,
   output logic             de_nop,
   output logic             em_nop,
   output logic             mw_nop,
   output logic             halt,
   output logic             dwait,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hazard_state_t    state_r;
   hazard_state_t    next_state_s;
   logic             halt_r;
   logic             dwait_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;
   logic             load_use_s;
   logic             dmem_wait_s;
   logic             stall_inc_s;
   logic             flush_inc_s;

   load_use_detect u_load_use_detect (
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .de_rs      (de_rs),
      .de_rt      (de_rt),
      .de_uses_rt (de_uses_rt),
      .hazard     (load_use_s)
   );

   assign dmem_wait_s = (mem_dren | mem_dwen) & ~dhit;

   // Same-cycle latch/PC controls, resolved in priority order.
   always_comb begin
      pc_en       = 1'b0;
      fd_pause    = 1'b0;
      de_pause    = 1'b0;
      em_pause    = 1'b0;
      mw_pause    = 1'b0;
      fd_nop      = 1'b0;
      de_nop      = 1'b0;
      em_nop      = 1'b0;
      mw_nop      = 1'b0;
      flush_inc_s = 1'b0;
      if (state_r == HALTED) begin
         fd_pause = 1'b1;
         de_pause = 1'b1;
         em_pause = 1'b1;
         mw_pause = 1'b1;
      end else if (dmem_wait_s) begin
         // Freeze front of pipe; MEM result is not ready so WB gets a bubble.
         fd_pause = 1'b1;
         de_pause = 1'b1;
         em_pause = 1'b1;
         mw_nop   = 1'b1;
      end else if (mem_halt) begin
         fd_nop = 1'b1;
         de_nop = 1'b1;
         em_nop = 1'b1;
      end else if (mem_redirect) begin
         // Target is selected by the PC mux, so load it even on a fetch miss.
         pc_en       = 1'b1;
         fd_nop      = 1'b1;
         de_nop      = 1'b1;
         em_nop      = 1'b1;
         flush_inc_s = 1'b1;
      end else if (load_use_s) begin
         fd_pause = 1'b1;
         de_nop   = 1'b1;
      end else if (!ihit) begin
         fd_nop = 1'b1;
      end else begin
         pc_en = 1'b1;
      end
      stall_inc_s = (state_r != HALTED) & ~pc_en;
   end

   // Next-state selection; HALTED is left only through reset.
   always_comb begin
      case (state_r)
         HALTED: next_state_s = HALTED;
         RUN, DWAIT: begin
            if (dmem_wait_s) begin
               next_state_s = DWAIT;
            end else if (mem_halt) begin
               next_state_s = HALTED;
            end else begin
               next_state_s = RUN;
            end
         end
         default: next_state_s = RUN;
      endcase
   end

   // FSM state, registered status flags and saturating counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r     <= RUN;
         halt_r      <= 1'b0;
         dwait_r     <= 1'b0;
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         halt_r  <= (next_state_s == HALTED);
         dwait_r <= (next_state_s == DWAIT);
         if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign halt      = halt_r;
   assign dwait     = dwait_r;
   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Central stall/flush controller for the 5-stage pipeline. It drives the pause/bubble controls of all four inter-stage latches (fetch/decode, decode/execute, execute/memory, memory/writeback) and the PC enable. It resolves instruction-memory wait, data-memory wait, load-use hazards, taken branch/jump redirects and halt. It also keeps a small FSM plus performance counters so the bench and the system top can observe stall behaviour.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall and flush counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access for the MEM-stage instruction completes this cycle.
- mem_dren, mem_dwen  in  1 each  MEM-stage instruction is a load / store.
- mem_redirect  in  1  taken branch or jump resolved in MEM; PC mux selects the target.
- mem_halt  in  1  halt instruction is in MEM.
- ex_memread  in  1  EX-stage instruction is a load.
- ex_rt  in  5  destination register of that load.
- de_rs, de_rt  in  5 each  source registers of the DE-stage instruction.
- de_uses_rt  in  1  DE-stage instruction reads rt as a source.
- pc_en  out  1  PC register loads its next value.
- fd_pause, de_pause, em_pause, mw_pause  out  1 each  latch holds its contents.
- fd_nop, de_nop, em_nop, mw_nop  out  1 each  latch loads zeros (bubble); nop overrides pause.
- halt  out  1  processor halted (sticky).
- dwait  out  1  FSM is in DWAIT.
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

## Operation
FSM states: RUN, DWAIT, HALTED.

Control outputs are combinational from state and inputs. Rules per cycle, highest priority first:
1. **HALTED:** pc_en=0, all four pause=1, all nop=0, halt=1. Only nRST leaves this state.
2. **Data wait:** (mem_dren|mem_dwen) & !dhit.
   - pc_en=0; fd_pause, de_pause, em_pause=1; mw_nop=1.
   - Next state DWAIT.
   - When dhit arrives in DWAIT, that cycle follows the RUN rules and the next state is RUN.
3. **Halt:** mem_halt.
   - pc_en=0; fd_nop, de_nop, em_nop=1; mw loads normally.
   - Next state HALTED.
4. **Redirect:** mem_redirect.
   - pc_en=1 regardless of ihit; fd_nop, de_nop, em_nop=1.
   - flush_cnt +1.
5. **Load-use:** ex_memread & ex_rt!=0 & (ex_rt==de_rs | (de_uses_rt & ex_rt==de_rt)).
   - pc_en=0; fd_pause=1; de_nop=1.
   - Takes priority over rule 6 when both apply.
6. **Fetch wait:** !ihit.
   - pc_en=0; fd_nop=1.
7. **Otherwise:** pc_en=1, all pause/nop=0.

Counters:
- stall_cnt +1 on every non-HALTED cycle where pc_en=0.
- Both counters saturate at all-ones and never wrap.

Unused pause/nop outputs are 0 in every rule.

## Timing
- Zero-latency control: outputs reflect same-cycle inputs. State and counters update on the rising edge of CLK.
- Reset values (immediate on nRST low):
  - State RUN; halt=0, dwait=0; stall_cnt=flush_cnt=0.
  - Combinational outputs then follow the RUN rules.
- Load-use costs exactly 1 bubble. Once DE holds the stalled instruction and EX holds the bubble, ex_memread=0, so the next cycle proceeds.
- Redirect costs 3 flushed slots.
- A store/load waiting N cycles for dhit freezes the PC and FD/DE/EM for N cycles and injects N bubbles into MW.
- Simultaneous mem_redirect and load-use: redirect wins; no stall is counted.
- nRST asserted in any state, including mid-DWAIT: return to RUN immediately; counters cleared.

## Structure
- Add the hazard_state_t enum {RUN, DWAIT, HALTED} and the REGBITS-width register type to cpu_types_pkg.
- One combinational sub-module, load_use_detect (ex_memread, ex_rt, de_rs, de_rt, de_uses_rt -> hazard), reused by the forwarding work.

## Test plan
- **Load-use:** ex_memread=1, ex_rt=8, de_rs=8, ihit=1 -> pc_en=0, fd_pause=1, de_nop=1 for 1 cycle; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- **Data wait:** mem_dren=1, dhit low 3 cycles then high -> dwait=1 on cycles 2-4; mw_nop=1 and em_pause=1 for 3 cycles, release on the dhit cycle; stall_cnt=3.
- **Redirect with fetch miss:** mem_redirect=1 with ihit=0 -> pc_en=1, fd/de/em_nop=1; flush_cnt=1.
- **Redirect with load-use:** mem_redirect=1 plus load-use match -> flush only; fd_pause=0; stall_cnt unchanged.
- **Halt:** mem_halt=1 -> next cycle halt=1 and all pause=1; stays halted for 10 cycles regardless of inputs; nRST pulse -> halt=0, counters 0.
- **Saturation:** CNT_W=4, ihit=0 for 20 cycles -> stall_cnt holds at 15.
